psx_irq_dispatch: RTL and testbench
===================================

Name: psx_irq_dispatch

Overview:
CPU-side consumer of the PSX interrupt controller's I_STAT/I_MASK outputs. It merges pending hardware lines with the COP0 software-interrupt bits and produces the COP0 Cause IP field. It gates that field with COP0 SR IM/IEc and raises an exception request to the pipeline using a req/ack handshake. It then holds off re-requesting until the handler executes RFE, so a still-pending line cannot retrigger mid-entry.

Parameters:
NUM_IRQ, 11, number of hardware interrupt lines used from stat_i/mask_i (bits NUM_IRQ-1:0).
HOLDOFF, 2, cycles after RFE before a new request may be raised; 0 means return to IDLE on the RFE cycle.

Ports:
sys_clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
stat_i  in  32  I_STAT from interrupt controller
mask_i  in  32  I_MASK from interrupt controller
sr_iec  in  1  COP0 SR bit 0, current interrupt enable
sr_im  in  8  COP0 SR IM field (SR[15:8])
cause_sw  in  2  COP0 Cause software-interrupt bits IP1:IP0
exc_ack  in  1  pipeline accepted the interrupt exception, 1-cycle pulse
rfe  in  1  pipeline retired RFE, 1-cycle pulse
exc_req  out  1  interrupt exception request to pipeline
cause_ip  out  8  value for COP0 Cause[15:8]
irq_id  out  4  lowest-numbered pending-and-unmasked line; 4'hF if none
irq_count  out  16  number of accepted interrupt exceptions, saturating

Behaviour:
- Reset (async, rst high): state IDLE, exc_req=0, cause_ip=0, irq_id=4'hF, irq_count=0, hw_pending_q=0, holdoff counter=0. Takes effect immediately, including mid-REQ; exc_req drops without waiting for a clock.
- hw_pending_q: register, loaded each edge with |(stat_i[NUM_IRQ-1:0] & mask_i[NUM_IRQ-1:0]). stat_i/mask_i bits above NUM_IRQ-1 are ignored.
- cause_ip (combinational from registers/inputs) = {5'b0, hw_pending_q, cause_sw}. Bit 2 is hardware IP2; bits 7:3 are always 0.
- active (combinational) = sr_iec & |(cause_ip & sr_im).
- irq_id: register, updated every edge with the lowest index i where stat_i[i]&mask_i[i]=1, else 4'hF. It is independent of the FSM.
- FSM states: IDLE, REQ, HANDLER, HOLD. exc_req = (state==REQ), decoded from the state register.
  - IDLE: if active, go to REQ.
  - REQ: if exc_ack, go to HANDLER and increment irq_count (hold at 16'hFFFF). Else if !active (source cleared, masked, or IEc=0), go to IDLE as a withdrawal. exc_ack and !active in the same cycle: ack wins.
  - HANDLER: wait for rfe. On rfe, go to HOLD and load the counter with HOLDOFF-1; if HOLDOFF==0, go to IDLE instead.
  - HOLD: decrement the counter each cycle; when the counter is 0, go to IDLE. active is ignored in this state.
- exc_ack outside REQ is ignored; it changes neither state nor count. rfe outside HANDLER is ignored.
- Latency, hardware source: stat&mask becomes nonzero before edge k; hw_pending_q=1 after edge k; exc_req=1 after edge k+1 (2 cycles).
- Latency, software source: a cause_sw bit with matching IM and IEc gives exc_req=1 after the next edge (1 cycle).
- Request persistence: after REQ→HANDLER, a still-pending source re-requests only after RFE plus HOLDOFF cycles, then 1 cycle IDLE→REQ.
- Masking a line in I_MASK while in HANDLER has no effect on state; it only updates cause_ip/irq_id.

Test Plan:
1. Reset: rst pulse mid-REQ → exc_req falls asynchronously; cause_ip=8'h00, irq_id=4'hF, irq_count=0.
2. Basic hardware path: sr_iec=1, sr_im=8'h04, mask=32'h1, stat=32'h1 before edge 0 → cause_ip=8'h04 after edge 0, exc_req=1 after edge 1. exc_ack at cycle 3 → exc_req=0, irq_count=1.
3. Priority: stat=32'h0000_0070, mask=32'h0000_0060 → irq_id=4'h5. Then mask=0 → irq_id=4'hF, cause_ip[2]=0.
4. Withdrawal: enter REQ, clear sr_iec before ack → IDLE next edge, exc_req=0, irq_count unchanged. Then ack and sr_iec=0 in the same cycle from REQ → HANDLER, count+1.
5. Holdoff with HOLDOFF=2: line stays pending, ack then rfe at cycle t → exc_req=0 through t+2, exc_req=1 after edge t+3. Spurious rfe in IDLE → no change.
6. Software and saturation: sr_im=8'h01, cause_sw=2'b01, sr_iec=1, stat=0 → exc_req=1 one cycle later. Preload 65535 acks → irq_count=16'hFFFF and stays at 16'hFFFF after a further ack.

Source files
------------

// File: rtl/psx_irq_dispatch_if.sv
// Signal bundle between the interrupt dispatcher, the interrupt controller and the CPU pipeline.
// The master side drives the controller/COP0/pipeline inputs; the slave side is the dispatcher.
interface psx_irq_dispatch_if;
  logic [31:0] stat_i;
  logic [31:0] mask_i;
  logic        sr_iec;
  logic [7:0]  sr_im;
  logic [1:0]  cause_sw;
  logic        exc_ack;
  logic        rfe;
  logic        exc_req;
  logic [7:0]  cause_ip;
  logic [3:0]  irq_id;
  logic [15:0] irq_count;

  modport master (
    output stat_i, mask_i, sr_iec, sr_im, cause_sw, exc_ack, rfe,
    input  exc_req, cause_ip, irq_id, irq_count
  );

  modport slave (
    input  stat_i, mask_i, sr_iec, sr_im, cause_sw, exc_ack, rfe,
    output exc_req, cause_ip, irq_id, irq_count
  );
endinterface

// File: rtl/psx_irq_dispatch.sv
// Merges PSX I_STAT/I_MASK with COP0 software bits into Cause.IP and requests the
// interrupt exception, holding off re-requests until RFE plus a short guard interval.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an enabled pending source
// REQ     | exc_req asserted, waiting for the pipeline to take the exception
// HANDLER | exception taken, waiting for the handler's RFE
// HOLD    | guard interval after RFE before a new request is allowed
module psx_irq_dispatch #(
  parameter int          NUM_IRQ  = 11,
  parameter int          HOLDOFF  = 2,
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input logic            sys_clk,
  input logic            rst,
  psx_irq_dispatch_if.slave bus
);

  localparam int CW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HO_LOAD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       count_q, count_d;
  logic              hw_pending_q;
  logic [3:0]        irq_id_q, id_d;
  logic [NUM_IRQ-1:0] pend_vec;
  logic [7:0]        cause_ip;
  logic              active;
  logic              unused_hi;

  assign pend_vec  = bus.stat_i[NUM_IRQ-1:0] & bus.mask_i[NUM_IRQ-1:0];
  assign unused_hi = ^{bus.stat_i[31:NUM_IRQ], bus.mask_i[31:NUM_IRQ]};

  assign cause_ip = {5'b00000, hw_pending_q, bus.cause_sw};
  assign active   = bus.sr_iec & (|(cause_ip & bus.sr_im));

  // Lowest-numbered line wins; scan from the top so the last hit is the lowest.
  always_comb begin
    id_d = 4'hF;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_vec[i]) id_d = 4'(i);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      count_q      <= CNT_INIT;
      hw_pending_q <= 1'b0;
      irq_id_q     <= 4'hF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      hw_pending_q <= |pend_vec;
      irq_id_q     <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (active) state_d = REQ;
      end
      REQ: begin
        // Ack takes priority over a simultaneous withdrawal: the pipeline already committed.
        if (bus.exc_ack) begin
          state_d = HANDLER;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end else if (!active) begin
          state_d = IDLE;
        end
      end
      HANDLER: begin
        if (bus.rfe) begin
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = HO_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.exc_req   = (state_q == REQ);
  assign bus.cause_ip  = cause_ip;
  assign bus.irq_id    = irq_id_q;
  assign bus.irq_count = count_q;

endmodule

// File: tb/tb_psx_irq_dispatch.sv
// Self-checking bench for psx_irq_dispatch: directed sequences plus an accepted-exception
// scoreboard; a second instance with HOLDOFF=0 and a preloaded counter covers saturation.
module tb_psx_irq_dispatch;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  always #5 sys_clk = ~sys_clk;

  psx_irq_dispatch_if bus ();
  psx_irq_dispatch_if sbus ();

  psx_irq_dispatch #(.NUM_IRQ(11), .HOLDOFF(2)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  psx_irq_dispatch #(.NUM_IRQ(11), .HOLDOFF(0), .CNT_INIT(16'hFFFD)) dut_sat (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (sbus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_cnt = 16'h0000;
  logic [15:0] prev_cnt  = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Pulse exc_ack on the main DUT; when the bench expects REQ, the model count moves.
  task automatic ack_main(input bit counted);
    bus.exc_ack = 1'b1;
    if (counted) begin
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      exp_q.push_back(model_cnt);
    end
    tick(1);
    bus.exc_ack = 1'b0;
  endtask

  task automatic rfe_main();
    bus.rfe = 1'b1;
    tick(1);
    bus.rfe = 1'b0;
  endtask

  // Scoreboard: every change of irq_count must match the next queued expectation.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        prev_cnt = 16'h0000;
      end else if (bus.irq_count !== prev_cnt) begin
        if (exp_q.size() == 0) chk("sb_unexpected_count", 32'(bus.irq_count), 32'(prev_cnt));
        else                   chk("sb_count", 32'(bus.irq_count), 32'(exp_q.pop_front()));
        prev_cnt = bus.irq_count;
      end
    end
  end

  initial begin
    bus.stat_i = '0;  bus.mask_i = '0;  bus.sr_iec = 1'b0;  bus.sr_im = '0;
    bus.cause_sw = '0; bus.exc_ack = 1'b0; bus.rfe = 1'b0;
    sbus.stat_i = '0; sbus.mask_i = '0; sbus.sr_iec = 1'b0; sbus.sr_im = '0;
    sbus.cause_sw = '0; sbus.exc_ack = 1'b0; sbus.rfe = 1'b0;
    tick(2);
    rst = 1'b0;

    // 1: async reset mid-REQ
    bus.sr_iec = 1'b1; bus.sr_im = 8'h04; bus.mask_i = 32'h1; bus.stat_i = 32'h1;
    tick(2);
    chk("rst_pre_req", 32'(bus.exc_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_async", 32'(bus.exc_req), 32'd0);
    chk("rst_cause_ip", 32'(bus.cause_ip), 32'h00);
    chk("rst_irq_id", 32'(bus.irq_id), 32'hF);
    chk("rst_irq_count", 32'(bus.irq_count), 32'd0);
    chk("rst_sat_count", 32'(sbus.irq_count), 32'hFFFD);
    bus.stat_i = '0; bus.mask_i = '0; bus.sr_iec = 1'b0; bus.sr_im = '0;
    tick(1);
    rst = 1'b0;
    tick(1);

    // 2: hardware path latency and ack
    bus.sr_iec = 1'b1; bus.sr_im = 8'h04; bus.mask_i = 32'h1; bus.stat_i = 32'h1;
    tick(1);
    chk("hw_cause_ip_e0", 32'(bus.cause_ip), 32'h04);
    chk("hw_req_e0", 32'(bus.exc_req), 32'd0);
    tick(1);
    chk("hw_req_e1", 32'(bus.exc_req), 32'd1);
    chk("hw_irq_id", 32'(bus.irq_id), 32'h0);
    ack_main(1'b1);
    chk("hw_req_after_ack", 32'(bus.exc_req), 32'd0);
    chk("hw_count_after_ack", 32'(bus.irq_count), 32'd1);

    // 3: priority / upper-bit masking while in HANDLER
    bus.stat_i = 32'h0000_0070; bus.mask_i = 32'h0000_0060;
    tick(1);
    chk("prio_id5", 32'(bus.irq_id), 32'h5);
    chk("prio_cause_ip", 32'(bus.cause_ip), 32'h04);
    bus.mask_i = 32'h0;
    tick(1);
    chk("prio_id_none", 32'(bus.irq_id), 32'hF);
    chk("prio_ip2_clear", 32'(bus.cause_ip), 32'h00);
    chk("prio_handler_req", 32'(bus.exc_req), 32'd0);
    bus.stat_i = 32'hFFFF_F800; bus.mask_i = 32'hFFFF_F800;
    tick(1);
    chk("high_bits_id", 32'(bus.irq_id), 32'hF);
    chk("high_bits_ip", 32'(bus.cause_ip), 32'h00);
    bus.stat_i = 32'h0000_0400; bus.mask_i = 32'h0000_07FF;
    tick(1);
    chk("top_line_id", 32'(bus.irq_id), 32'hA);
    chk("top_line_ip", 32'(bus.cause_ip), 32'h04);
    bus.stat_i = 32'h1; bus.mask_i = 32'h1;
    tick(1);

    // 5: holdoff after RFE with the line still pending
    rfe_main();
    chk("hold_t0", 32'(bus.exc_req), 32'd0);
    tick(1);
    chk("hold_t1", 32'(bus.exc_req), 32'd0);
    tick(1);
    chk("hold_t2", 32'(bus.exc_req), 32'd0);
    tick(1);
    chk("hold_t3_req", 32'(bus.exc_req), 32'd1);
    ack_main(1'b1);
    chk("hold_ack_req", 32'(bus.exc_req), 32'd0);

    // 4: withdrawal, ignored pulses in IDLE, ack beats withdrawal
    rfe_main();
    tick(3);
    chk("wd_in_req", 32'(bus.exc_req), 32'd1);
    bus.sr_iec = 1'b0;
    tick(1);
    chk("wd_req_drop", 32'(bus.exc_req), 32'd0);
    chk("wd_count_same", 32'(bus.irq_count), 32'(model_cnt));
    rfe_main();
    chk("spur_rfe_idle", 32'(bus.exc_req), 32'd0);
    ack_main(1'b0);
    chk("spur_ack_count", 32'(bus.irq_count), 32'(model_cnt));
    bus.sr_iec = 1'b1;
    tick(1);
    chk("wd_rereq", 32'(bus.exc_req), 32'd1);
    bus.sr_iec = 1'b0;
    ack_main(1'b1);
    chk("ackwd_req", 32'(bus.exc_req), 32'd0);
    bus.sr_iec = 1'b1;
    tick(2);
    chk("ackwd_in_handler", 32'(bus.exc_req), 32'd0);

    // 6: software source latency
    bus.stat_i = '0; bus.mask_i = '0;
    tick(1);
    rfe_main();
    tick(2);
    chk("sw_idle", 32'(bus.exc_req), 32'd0);
    bus.sr_im = 8'h01; bus.cause_sw = 2'b01;
    #1;
    chk("sw_cause_ip", 32'(bus.cause_ip), 32'h01);
    tick(1);
    chk("sw_req_1cyc", 32'(bus.exc_req), 32'd1);
    ack_main(1'b1);

    // saturation and HOLDOFF=0 on the preloaded instance
    sbus.sr_iec = 1'b1; sbus.sr_im = 8'h02; sbus.cause_sw = 2'b10;
    tick(1);
    chk("sat_req", 32'(sbus.exc_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      sbus.exc_ack = 1'b1;
      tick(1);
      sbus.exc_ack = 1'b0;
      chk("sat_count", 32'(sbus.irq_count), (k == 0) ? 32'hFFFE : 32'hFFFF);
      sbus.rfe = 1'b1;
      tick(1);
      sbus.rfe = 1'b0;
      chk("ho0_after_rfe", 32'(sbus.exc_req), 32'd0);
      tick(1);
      chk("ho0_rereq", 32'(sbus.exc_req), 32'd1);
    end

    tick(1);
    #5;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
